// File: rtl/norm_arbiter_if.sv
// norm_arbiter_if: two-requester operand handshake plus normalized-result handshake
interface norm_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [7:0]  req0_exp;
    logic [27:0] req0_mantis;
    logic        req1_valid;
    logic        req1_ready;
    logic [7:0]  req1_exp;
    logic [27:0] req1_mantis;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exp;
    logic [27:0] out_mantis;
    logic        out_id;

    modport slave (
        input  req0_valid, req0_exp, req0_mantis,
        input  req1_valid, req1_exp, req1_mantis,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_exp, out_mantis, out_id
    );

    modport master (
        output req0_valid, req0_exp, req0_mantis,
        output req1_valid, req1_exp, req1_mantis,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_exp, out_mantis, out_id
    );
endinterface

// File: rtl/norm_arbiter.sv
// norm_arbiter: two requesters share one normalizer behind a single-entry output register; define NORM_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority to requester 0
module norm_normalize (
    input  logic [7:0]  i_exp,
    input  logic [27:0] i_mantis,
    output logic [7:0]  o_exp,
    output logic [27:0] o_mantis
);
    logic [4:0] w_lz;
    logic [7:0] w_shift;
    logic       w_fits;

    // leading-zero count: the highest set bit is visited last and wins; a zero mantissa gives 0
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < 28; i++)
            if (i_mantis[i]) w_lz = 5'(27 - i);
    end

    assign w_shift = {3'b000, w_lz};
    assign w_fits  = i_exp >= w_shift;

    // when the exponent cannot absorb the full shift, stop at exponent 0 (partially normalized)
    always_comb begin
        o_exp    = w_fits ? i_exp - w_shift : 8'd0;
        o_mantis = w_fits ? i_mantis << w_lz : i_mantis << i_exp;
    end
endmodule

module norm_arbiter (
    input  logic         clk,
    input  logic         rst,
    norm_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_sel;
    logic        w_can_accept;
    logic        w_accept;
    logic [7:0]  w_in_exp;
    logic [27:0] w_in_mantis;
    logic [7:0]  w_norm_exp;
    logic [27:0] w_norm_mantis;
    logic [7:0]  r_exp;
    logic [27:0] r_mantis;
    logic        r_id;

`ifdef NORM_ARB_ROUND_ROBIN_EN
    logic r_ptr;

    // pointer names the requester preferred on a tie; after each transfer it moves to the other one
    always_ff @(posedge clk or posedge rst)
        if (rst) r_ptr <= 1'b0;
        else if (w_accept) r_ptr <= ~w_sel;

    // a lone valid always wins; on a tie the pointer decides
    always_comb begin
        w_grant0 = bus.req0_valid & (~bus.req1_valid | ~r_ptr);
        w_grant1 = bus.req1_valid & (~bus.req0_valid | r_ptr);
    end
`else
    // fixed priority: requester 0 wins every tie
    always_comb begin
        w_grant0 = bus.req0_valid;
        w_grant1 = bus.req1_valid & ~bus.req0_valid;
    end
`endif

    // the output slot is free when empty or being drained this cycle; nothing is accepted during reset
    assign w_can_accept   = ~rst & ((r_state == EMPTY) | bus.out_ready);
    assign w_accept       = (w_grant0 | w_grant1) & w_can_accept;
    assign w_sel          = w_grant1;
    assign w_in_exp       = w_sel ? bus.req1_exp : bus.req0_exp;
    assign w_in_mantis    = w_sel ? bus.req1_mantis : bus.req0_mantis;
    assign bus.req0_ready = w_grant0 & w_can_accept;
    assign bus.req1_ready = w_grant1 & w_can_accept;

    norm_normalize u_norm (
        .i_exp    (w_in_exp),
        .i_mantis (w_in_mantis),
        .o_exp    (w_norm_exp),
        .o_mantis (w_norm_mantis)
    );

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= EMPTY;
        else r_state <= w_next;

    // an accept always fills the slot (reload on drain); a drain without accept empties it
    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = FULL;
        else if (r_state == FULL && bus.out_ready) w_next = EMPTY;
    end

    // result register loads only on an accepted transfer, otherwise holds
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_exp    <= '0;
            r_mantis <= '0;
            r_id     <= 1'b0;
        end else if (w_accept) begin
            r_exp    <= w_norm_exp;
            r_mantis <= w_norm_mantis;
            r_id     <= w_sel;
        end

    assign bus.out_valid  = r_state == FULL;
    assign bus.out_exp    = r_exp;
    assign bus.out_mantis = r_mantis;
    assign bus.out_id     = r_id;

    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(bus.req0_ready && bus.req1_ready));
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (r_state == FULL && !bus.out_ready) |=> ($stable(r_exp) && $stable(r_mantis) && $stable(r_id)));
endmodule

// File: tb/tb_norm_arbiter.sv
// tb_norm_arbiter: directed vectors with a queue scoreboard checked by an independent output monitor
module tb_norm_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [36:0] q[$];

    norm_arbiter_if bus();

    norm_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic send(input bit id, input logic [7:0] e, input logic [27:0] m,
                        input logic [7:0] xe, input logic [27:0] xm);
        bit done = 1'b0;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_exp = e; bus.req1_mantis = m;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_exp = e; bus.req0_mantis = m;
        end
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            if (id ? bus.req1_ready : bus.req0_ready) begin
                q.push_back({xe, xm, id});
                done = 1'b1;
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("send_accepted", {63'b0, done}, 64'd1);
    endtask

    always @(negedge clk) begin
        #3;
        if (!rst) begin
            chk("one_ready", {63'b0, bus.req0_ready & bus.req1_ready}, 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected none", {bus.out_exp, bus.out_mantis, bus.out_id});
                end else
                    chk("result", {27'b0, bus.out_exp, bus.out_mantis, bus.out_id}, {27'b0, q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 1'b1; bus.req0_exp = '0; bus.req0_mantis = '0;
        bus.req1_valid = 1'b1; bus.req1_exp = '0; bus.req1_mantis = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_out_data", {bus.out_exp, bus.out_mantis, bus.out_id}, 64'd0);
        chk("rst_ready", {62'b0, bus.req0_ready, bus.req1_ready}, 64'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send(1'b0, 8'd10, 28'h0100000, 8'd3, 28'h8000000);
        #1;
        chk("latency_valid", {63'b0, bus.out_valid}, 64'd1);
        @(negedge clk);
        send(1'b1, 8'd3, 28'h0000010, 8'd0, 28'h0000080);
        send(1'b1, 8'd5, 28'h0000000, 8'd5, 28'h0000000);

        bus.req0_valid = 1'b1; bus.req0_exp = 8'd20; bus.req0_mantis = 28'h0000001;
        bus.req1_valid = 1'b1; bus.req1_exp = 8'd40; bus.req1_mantis = 28'h0F00000;
        for (int i = 0; i < 4; i++) begin
            bit xid;
`ifdef NORM_ARB_ROUND_ROBIN_EN
            xid = i[0];
`else
            xid = 1'b0;
`endif
            #1;
            chk("contention_ready", {63'b0, bus.req0_ready | bus.req1_ready}, 64'd1);
            q.push_back(xid ? {8'd36, 28'hF000000, 1'b1} : {8'd0, 28'h0100000, 1'b0});
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);

        bus.out_ready = 1'b0;
        send(1'b0, 8'd10, 28'h0100000, 8'd3, 28'h8000000);
        bus.req0_valid = 1'b1; bus.req0_exp = 8'd30; bus.req0_mantis = 28'h0000003;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_valid", {63'b0, bus.out_valid}, 64'd1);
            chk("hold_data", {bus.out_exp, bus.out_mantis, bus.out_id}, {8'd3, 28'h8000000, 1'b0});
            chk("hold_ready", {62'b0, bus.req0_ready, bus.req1_ready}, 64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.req1_valid = 1'b0;
        #1;
        chk("drain_accept", {63'b0, bus.req0_ready}, 64'd1);
        q.push_back({8'd4, 28'hC000000, 1'b0});
        @(negedge clk);
        bus.req0_valid = 1'b0;
        repeat (2) @(negedge clk);

        bus.out_ready = 1'b0;
        send(1'b1, 8'd3, 28'h0000010, 8'd0, 28'h0000080);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("async_rst_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("async_rst_data", {bus.out_exp, bus.out_mantis, bus.out_id}, 64'd0);
        chk("async_rst_ready", {62'b0, bus.req0_ready, bus.req1_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_tie", {62'b0, bus.req0_ready, bus.req1_ready}, 64'd2);
        q.push_back({8'd4, 28'hC000000, 1'b0});
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/norm_arbiter.md
NORM_ARBITER -- requirements
Module: norm_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester has an operand.
REQ-005 req0_ready / req1_ready  output  1 each  operand accepted this cycle when ready and valid are both high.
REQ-006 req0_exp / req1_exp  input  8 each  unnormalized exponent.
REQ-007 req0_mantis / req1_mantis  input  28 each  unnormalized mantissa.
REQ-008 out_valid  output  1  registered result present.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_exp  output  8  normalized exponent.
REQ-011 out_mantis  output  28  normalized mantissa.
REQ-012 out_id  output  1  index of the requester that owns the result.

Function
REQ-013 The block SHALL share one instance of the normalize module between the two requesters.
REQ-014 Normalize function: shift = leading-zero count of the mantissa, 0 for a zero mantissa.
REQ-015 Normalize function, exp >= shift: result = {exp-shift, mantis<<shift}.
REQ-016 Normalize function, exp < shift: result = {0, mantis<<exp}.
REQ-017 States: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 can_accept = EMPTY, or FULL with out_ready=1 (a single-entry output register with pass-through on drain).
REQ-019 Grant is combinational from the valid inputs and the priority pointer; at most one req*_ready SHALL be high per cycle.
REQ-020 reqN_ready = grantN & can_accept; reqN_ready SHALL NOT depend on reqN_valid of the same requester except through the grant.
REQ-021 On an accept, the normalized result and the requester id SHALL be registered at the next rising edge.
REQ-022 out_valid SHALL rise one cycle after acceptance (latency 1).
REQ-023 FULL & out_ready & accept: the register SHALL reload the same edge, out_valid stays 1, and back-to-back throughput is 1 per cycle.
REQ-024 FULL & out_ready & no accept: transition to EMPTY.
REQ-025 FULL & ~out_ready: out_exp, out_mantis and out_id SHALL hold stable, and both req*_ready SHALL be 0.
REQ-026 EMPTY & no valid: the state stays EMPTY and the data registers hold.
REQ-027 Only one valid is high: that requester SHALL be granted regardless of the pointer.
REQ-028 The priority pointer SHALL update only on an accepted transfer.

Reset
REQ-029 On rst high, out_valid=0, out_exp=0, out_mantis=0, out_id=0, state=EMPTY, and pointer=0 (requester 0 preferred) SHALL apply immediately, independent of clk.
REQ-030 Reset mid-operation SHALL discard any held result without emitting it.
REQ-031 While rst is high, both req*_ready SHALL be 0.

Configuration
REQ-032 Macro NORM_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-033 With the macro defined, round-robin SHALL apply: both valid -> grant the pointer's requester, and after each accepted transfer the pointer SHALL point to the other requester.
REQ-034 With the macro undefined, fixed priority SHALL apply: requester 0 always wins a tie, and the pointer register SHALL be absent or constant 0.

Verification
REQ-035 Basic normalize: req0 exp=8'd10, mantis=28'h0100000, out_ready=1 -> next cycle out_valid=1, out_exp=8'd3, out_mantis=28'h8000000, out_id=0.
REQ-036 Underflow and zero: req1 exp=8'd3, mantis=28'h0000010 -> out_exp=0, out_mantis=28'h0000080, out_id=1; then exp=8'd5, mantis=0 -> out_exp=5, out_mantis=0.
REQ-037 Contention (macro defined): both valid continuously, out_ready=1 -> out_id sequence 0,1,0,1 at one result per cycle; with the macro undefined -> out_id 0,0,0,0.
REQ-038 Backpressure: a result is held and out_ready=0 for 3 cycles -> outputs stable, req*_ready=0; out_ready=1 -> a new accept occurs in the same cycle, with no lost or duplicated result.
REQ-039 Reset: assert rst while FULL and out_ready=0 -> out_valid=0 with no clk edge needed; after release, the first tie is granted to requester 0.
